// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative mult/multu/div/divu unit, one bit per cycle.
// Ports: clk, resetn, start_i, op_i, opdata1_i/2_i, annul_i -> busy_o, ready_o, result_o, div_zero_o.
module iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    result_q, result_d;
  logic             div_zero_q, div_zero_d;

  logic             in_div, in_sgn, neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    step;
  logic             neg_res, neg_rem;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [W2-1:0]    fixed;

  // operand conditioning at acceptance
  always_comb begin
    in_div = op_i[1];
    in_sgn = ~op_i[0];
    neg1   = in_sgn & opdata1_i[WIDTH-1];
    neg2   = in_sgn & opdata2_i[WIDTH-1];
    mag1   = neg1 ? -opdata1_i : opdata1_i;
    mag2   = neg2 ? -opdata2_i : opdata2_i;
  end

  // one iteration; acc holds {hi, lo}
  // mult: lo starts as multiplier, shifts out LSB-first
  // div: lo starts as dividend, quotient bits shift in
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb_q};
    div_ge    = ~div_diff[WIDTH];
    div_rem   = div_ge ? div_diff[WIDTH-1:0]
                       : div_trial[WIDTH-1:0];
    if (op_q[1]) begin
      step = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // sign correction applied to the final iteration
  always_comb begin
    neg_res  = ~op_q[0] & (s1_q ^ s2_q);
    neg_rem  = ~op_q[0] & s1_q;
    prod_fix = neg_res ? -step : step;
    quo_fix  = neg_res ? -step[WIDTH-1:0]
                       : step[WIDTH-1:0];
    rem_fix  = neg_rem ? -step[W2-1:WIDTH]
                       : step[W2-1:WIDTH];
    fixed    = op_q[1] ? {rem_fix, quo_fix} : prod_fix;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    opb_d      = opb_q;
    acc_d      = acc_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          op_d  = op_i;
          s1_d  = neg1;
          s2_d  = neg2;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, in_div ? mag1 : mag2};
          opb_d = in_div ? mag2 : mag1;
          if (in_div && opdata2_i == '0) begin
            state_d    = S_DONE;
            result_d   = '0;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d    = S_DONE;
            result_d   = fixed;
            div_zero_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      opb_q      <= opb_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q == S_CALC);
  assign ready_o    = (state_q == S_DONE);
  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;

endmodule
